// File: rtl/bch_wrapper_decode_feeder.sv
// bch_wrapper_decode_feeder: assembles one BCH codeword for the decoder core.
// The block latches a received data word and fetches its ECC bits from
// memory. It then streams {data, ecc} MSB-first to the decoder as C_BITS-wide
// symbols.
//
// Ports:
//   I_clk, I_rst        clock and synchronous active-high reset
//   I_data, I_start     data word and start request (acts on a rising edge)
//   O_mem_raddr, O_ren  memory read port
//   I_mem_rdata         read data, valid the cycle after O_ren
//   I_dec_ready         decoder can accept a new codeword
//   O_dec_*             codeword symbol stream (start/first/last/valid/data)
//   O_busy, O_ready     busy level and one-cycle completion pulse
module bch_wrapper_decode_feeder #(
   parameter int C_DATA_BITS     = 16,
   parameter int C_ECC_BITS      = 10,
   parameter int C_BITS          = 1,
   parameter int C_I_MEMADDR     = 0,
   parameter int C_MEM_ADDR_SIZE = 10,
   parameter int C_MEM_DATA_SIZE = 8
) (
   input  logic                       I_clk,
   input  logic                       I_rst,
   input  logic [C_DATA_BITS-1:0]     I_data,
   input  logic                       I_start,
   output logic [C_MEM_ADDR_SIZE-1:0] O_mem_raddr,
   output logic                       O_ren,
   input  logic [C_MEM_DATA_SIZE-1:0] I_mem_rdata,
   input  logic                       I_dec_ready,
   output logic                       O_dec_start,
   output logic                       O_dec_first,
   output logic                       O_dec_last,
   output logic                       O_dec_valid,
   output logic [C_BITS-1:0]          O_dec_data,
   output logic                       O_busy,
   output logic                       O_ready
);
   localparam int D  = C_DATA_BITS;
   localparam int E  = C_ECC_BITS;
   localparam int M  = C_MEM_DATA_SIZE;
   localparam int A  = C_MEM_ADDR_SIZE;
   localparam int N  = (E + M - 1) / M;
   localparam int NM = N * M;
   localparam int W  = D + E;
   localparam int S  = W / C_BITS;
   localparam int NW = $clog2(N + 1);
   localparam int SW = $clog2(S + 1);
   localparam logic [A-1:0]  BASE   = A'(C_I_MEMADDR);
   localparam logic [NW-1:0] N_ALL  = NW'(N);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);
   localparam logic [SW-1:0] S_LAST = SW'(S - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_DEC, STREAM, DONE} state_t;

   state_t          state;
   logic            start_hist;
   logic            rvalid;
   logic [D-1:0]    data_q;
   logic [NM-1:0]   ecc_buf;
   logic [W-1:0]    cw;
   logic [W-1:0]    sh;
   logic [NW-1:0]   rd_cnt;
   logic [NW-1:0]   cap_cnt;
   logic [SW-1:0]   cnt;
   logic            go;

   assign cw = {data_q, ecc_buf[E-1:0]};
   // The first symbol leaves in the same cycle the decoder reports ready.
   assign go = (state == WAIT_DEC) && I_dec_ready;

   assign O_dec_valid = go || (state == STREAM);
   assign O_dec_start = go;
   assign O_dec_first = go;
   assign O_dec_last  = O_dec_valid && (cnt == S_LAST);
   assign O_dec_data  = go ? cw[W-1 -: C_BITS] : (state == STREAM) ? sh[W-1 -: C_BITS] : '0;
   assign O_busy      = state != IDLE;
   assign O_ready     = state == DONE;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state       <= IDLE;
         // Held high so an I_start already high at reset release is not an edge.
         start_hist  <= 1'b1;
         rvalid      <= 1'b0;
         O_ren       <= 1'b0;
         O_mem_raddr <= BASE;
         data_q      <= '0;
         ecc_buf     <= '0;
         sh          <= '0;
         rd_cnt      <= '0;
         cap_cnt     <= '0;
         cnt         <= '0;
      end else begin
         start_hist <= I_start;
         rvalid     <= O_ren;
         case (state)
            IDLE: if (I_start && !start_hist) begin
               data_q      <= I_data;
               O_ren       <= 1'b1;
               O_mem_raddr <= BASE;
               rd_cnt      <= NW'(1);
               cap_cnt     <= '0;
               cnt         <= '0;
               state       <= FETCH;
            end
            FETCH: begin
               if (O_ren) begin
                  if (rd_cnt == N_ALL) O_ren <= 1'b0;
                  else begin
                     O_mem_raddr <= O_mem_raddr + 1'b1;
                     rd_cnt      <= rd_cnt + 1'b1;
                  end
               end
               // Words shift in from the top so word 0 ends at the LSBs.
               if (rvalid) begin
                  ecc_buf <= NM'({I_mem_rdata, ecc_buf} >> M);
                  cap_cnt <= cap_cnt + 1'b1;
                  if (cap_cnt == N_LAST) state <= WAIT_DEC;
               end
            end
            WAIT_DEC: if (I_dec_ready) begin
               sh    <= cw << C_BITS;
               cnt   <= SW'(1);
               state <= (S == 1) ? DONE : STREAM;
            end
            STREAM: begin
               sh  <= sh << C_BITS;
               cnt <= cnt + 1'b1;
               if (cnt == S_LAST) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bch_wrapper_decode_feeder.sv
// tb_bch_wrapper_decode_feeder: directed bench for bch_wrapper_decode_feeder.
// Three instances share the stimulus:
//   u0  base 0x10, C_BITS=1
//   u1  base 0x3FF, for address wrap
//   u2  base 0x10, C_BITS=2
// Each run traces 40 cycles from the start edge (offset 0 = cycle T).
module tb_bch_wrapper_decode_feeder;
   logic        I_clk = 1'b0;
   logic        I_rst = 1'b1;
   logic        I_start = 1'b0;
   logic        I_dec_ready = 1'b0;
   logic [15:0] I_data = 16'h0;

   always #5 I_clk = ~I_clk;

   logic [7:0] mem [1024];

   logic [9:0] a0, a1, a2;
   logic       ren0, ren1, ren2;
   logic [7:0] rd0, rd1, rd2;
   logic       ds0, df0, dl0, dv0, dd0, busy0, rdy0;
   logic       ds1, df1, dl1, dv1, dd1, busy1, rdy1;
   logic       ds2, df2, dl2, dv2, busy2, rdy2;
   logic [1:0] dd2;

   always @(posedge I_clk) begin
      rd0 <= mem[a0];
      rd1 <= mem[a1];
      rd2 <= mem[a2];
   end

   bch_wrapper_decode_feeder #(.C_I_MEMADDR(16'h10)) u0 (
      .I_clk(I_clk), .I_rst(I_rst), .I_data(I_data), .I_start(I_start),
      .O_mem_raddr(a0), .O_ren(ren0), .I_mem_rdata(rd0), .I_dec_ready(I_dec_ready),
      .O_dec_start(ds0), .O_dec_first(df0), .O_dec_last(dl0), .O_dec_valid(dv0),
      .O_dec_data(dd0), .O_busy(busy0), .O_ready(rdy0));

   bch_wrapper_decode_feeder #(.C_I_MEMADDR(16'h3FF)) u1 (
      .I_clk(I_clk), .I_rst(I_rst), .I_data(I_data), .I_start(I_start),
      .O_mem_raddr(a1), .O_ren(ren1), .I_mem_rdata(rd1), .I_dec_ready(I_dec_ready),
      .O_dec_start(ds1), .O_dec_first(df1), .O_dec_last(dl1), .O_dec_valid(dv1),
      .O_dec_data(dd1), .O_busy(busy1), .O_ready(rdy1));

   bch_wrapper_decode_feeder #(.C_I_MEMADDR(16'h10), .C_BITS(2)) u2 (
      .I_clk(I_clk), .I_rst(I_rst), .I_data(I_data), .I_start(I_start),
      .O_mem_raddr(a2), .O_ren(ren2), .I_mem_rdata(rd2), .I_dec_ready(I_dec_ready),
      .O_dec_start(ds2), .O_dec_first(df2), .O_dec_last(dl2), .O_dec_valid(dv2),
      .O_dec_data(dd2), .O_busy(busy2), .O_ready(rdy2));

   int total = 0;
   int bad = 0;

   // Codewords {data, ecc}: ecc 0x3A5 from 0xA5/0x03, 0x15A from 0x5A/0xFD (top bits dropped).
   logic [25:0] cw0 = {16'hC3C3, 10'h3A5};
   logic [25:0] cw1 = {16'hC3C3, 10'h15A};

   // Trace packs: {ren, valid, data, start, first, last, ready, busy}
   logic [7:0] t0 [40];
   logic [7:0] t1 [40];
   logic [8:0] t2 [40];
   logic [9:0] ta0 [40];
   logic [9:0] ta1 [40];
   logic [9:0] ta2 [40];

   // Expected C_BITS=1 trace: reads at +1/+2, 26 symbols from offset s.
   function automatic logic [7:0] exp1(int i, int s, logic [25:0] cw);
      logic v;
      v = (i >= s) && (i < s + 26);
      return {(i == 1 || i == 2), v, v ? cw[25 - (i - s)] : 1'b0,
              (i == s), (i == s), (i == s + 25), (i == s + 26), (i >= 1 && i <= s + 26)};
   endfunction

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   // One codeword from a start edge at offset 0; I_dec_ready rises at ready_at,
   // a second start edge at retrig_at, reset for one cycle at rst_at.
   task automatic run_cw(input int ready_at, input int retrig_at, input int rst_at);
      I_start = 1'b0;
      I_rst = 1'b0;
      I_dec_ready = (ready_at <= 0);
      I_data = 16'h0F0F;
      step();
      for (int i = 0; i < 40; i++) begin
         if (i > 0) step();
         I_start = (i == 0) || (i == retrig_at);
         I_dec_ready = (i >= ready_at);
         I_rst = (i == rst_at);
         I_data = (i == 0) ? 16'hC3C3 : 16'h0F0F ^ 16'(i);
         #1;
         t0[i] = {ren0, dv0, dd0, ds0, df0, dl0, rdy0, busy0};
         t1[i] = {ren1, dv1, dd1, ds1, df1, dl1, rdy1, busy1};
         t2[i] = {ren2, dv2, dd2, ds2, df2, dl2, rdy2, busy2};
         ta0[i] = a0;
         ta1[i] = a1;
         ta2[i] = a2;
      end
      I_rst = 1'b0;
      I_start = 1'b0;
      step();
   endtask

   task automatic test_reset();
      I_rst = 1'b1;
      I_start = 1'b1;
      I_dec_ready = 1'b1;
      step();
      step();
      total++;
      if ({ren0, dv0, dd0, ds0, df0, dl0, rdy0, busy0} !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 00000000", {ren0, dv0, dd0, ds0, df0, dl0, rdy0, busy0});
      end
      total++;
      if (a0 !== 10'h010 || a1 !== 10'h3FF) begin
         bad++;
         $display("FAIL reset_addr: got %h/%h want 010/3ff", a0, a1);
      end
      total++;
      if ({ren2, dv2, dd2, busy2, rdy2} !== 6'h00) begin
         bad++;
         $display("FAIL reset_u2: got %b want 000000", {ren2, dv2, dd2, busy2, rdy2});
      end
      I_rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({busy0, ren0, busy1, busy2} !== 4'h0) begin
            bad++;
            $display("FAIL held_start[%0d]: got %b want 0000", i, {busy0, ren0, busy1, busy2});
         end
      end
      I_start = 1'b0;
      step();
   endtask

   task automatic test_nominal();
      run_cw(0, -1, -1);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (t0[i] !== exp1(i, 4, cw0)) begin
            bad++;
            $display("FAIL nominal[%0d]: got %b want %b", i, t0[i], exp1(i, 4, cw0));
         end
      end
      total++;
      if (ta0[1] !== 10'h010 || ta0[2] !== 10'h011) begin
         bad++;
         $display("FAIL nominal_addr: got %h,%h want 010,011", ta0[1], ta0[2]);
      end
   endtask

   task automatic test_stall();
      run_cw(10, -1, -1);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (t0[i] !== exp1(i, 10, cw0)) begin
            bad++;
            $display("FAIL stall[%0d]: got %b want %b", i, t0[i], exp1(i, 10, cw0));
         end
      end
   endtask

   task automatic test_retrigger();
      int nrdy;
      int nren;
      nrdy = 0;
      nren = 0;
      run_cw(0, 12, -1);
      for (int i = 0; i < 40; i++) begin
         nrdy += int'(t0[i][1]);
         nren += int'(t0[i][7]);
         total++;
         if (t0[i] !== exp1(i, 4, cw0)) begin
            bad++;
            $display("FAIL retrigger[%0d]: got %b want %b", i, t0[i], exp1(i, 4, cw0));
         end
      end
      total++;
      if (nrdy != 1 || nren != 2) begin
         bad++;
         $display("FAIL retrigger_counts: ready=%0d ren=%0d want 1 and 2", nrdy, nren);
      end
   endtask

   task automatic test_reset_mid();
      run_cw(0, -1, 15);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (t0[i] !== ((i <= 15) ? exp1(i, 4, cw0) : 8'h00)) begin
            bad++;
            $display("FAIL reset_mid[%0d]: got %b want %b", i, t0[i], (i <= 15) ? exp1(i, 4, cw0) : 8'h00);
         end
      end
      total++;
      if (ta0[16] !== 10'h010) begin
         bad++;
         $display("FAIL reset_mid_addr: got %h want 010", ta0[16]);
      end
   endtask

   task automatic test_restart();
      run_cw(0, -1, -1);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (t0[i] !== exp1(i, 4, cw0)) begin
            bad++;
            $display("FAIL restart[%0d]: got %b want %b", i, t0[i], exp1(i, 4, cw0));
         end
      end
   endtask

   task automatic test_wrap();
      run_cw(0, -1, -1);
      total++;
      if (ta1[1] !== 10'h3FF || ta1[2] !== 10'h000) begin
         bad++;
         $display("FAIL wrap_addr: got %h,%h want 3ff,000", ta1[1], ta1[2]);
      end
      for (int i = 0; i < 40; i++) begin
         total++;
         if (t1[i] !== exp1(i, 4, cw1)) begin
            bad++;
            $display("FAIL wrap[%0d]: got %b want %b", i, t1[i], exp1(i, 4, cw1));
         end
      end
   endtask

   task automatic test_multibit();
      logic [8:0] e;
      logic       v;
      run_cw(0, -1, -1);
      for (int i = 0; i < 40; i++) begin
         v = (i >= 4) && (i <= 16);
         e = {(i == 1 || i == 2), v, v ? cw0[25 - 2 * (i - 4) -: 2] : 2'b00,
              (i == 4), (i == 4), (i == 16), (i == 17), (i >= 1 && i <= 17)};
         total++;
         if (t2[i] !== e) begin
            bad++;
            $display("FAIL multibit[%0d]: got %b want %b", i, t2[i], e);
         end
      end
      total++;
      if (t2[4][6:5] !== 2'b11 || t2[16][6:5] !== 2'b01 || ta2[2] !== 10'h011) begin
         bad++;
         $display("FAIL multibit_ends: got %b,%b,%h want 11,01,011", t2[4][6:5], t2[16][6:5], ta2[2]);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
      mem[10'h010] = 8'hA5;
      mem[10'h011] = 8'h03;
      mem[10'h3FF] = 8'h5A;
      mem[10'h000] = 8'hFD;
      test_reset();
      test_nominal();
      test_stall();
      test_retrigger();
      test_reset_mid();
      test_restart();
      test_wrap();
      test_multibit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
